// File: rtl/neighbor_link_multicontext_if.sv
// Neighbor-facing bundle of the multi-context link: growth/error requests and exposed data.
// master = processing-unit side, slave = link side.
interface neighbor_link_multicontext_if #(
  parameter int unsigned EXPOSED_DATA_SIZE = 13
);
  logic                         a_increase;
  logic                         b_increase;
  logic                         a_is_error_in;
  logic                         b_is_error_in;
  logic [EXPOSED_DATA_SIZE-1:0] a_input_data;
  logic [EXPOSED_DATA_SIZE-1:0] b_input_data;
  logic [EXPOSED_DATA_SIZE-1:0] a_output_data;
  logic [EXPOSED_DATA_SIZE-1:0] b_output_data;

  modport master (
    output a_increase,
    output b_increase,
    output a_is_error_in,
    output b_is_error_in,
    output a_input_data,
    output b_input_data,
    input  a_output_data,
    input  b_output_data
  );

  modport slave (
    input  a_increase,
    input  b_increase,
    input  a_is_error_in,
    input  b_is_error_in,
    input  a_input_data,
    input  b_input_data,
    output a_output_data,
    output b_output_data
  );
endinterface

// File: rtl/neighbor_link_multicontext.sv
// Neighbor link time-multiplexed over NUM_CONTEXTS decoding contexts, one active at a time.
// Optional NEIGHBOR_LINK_ERASURE_EN adds erasure_in: measurement loading pre-grows the link.
module neighbor_link_multicontext #(
  parameter int unsigned ADDRESS_WIDTH     = 6,
  parameter int unsigned MAX_WEIGHT        = 2,
  parameter int unsigned NUM_CONTEXTS      = 4,
  parameter int unsigned EXPOSED_DATA_SIZE = ADDRESS_WIDTH + 7,
  parameter int unsigned STAGE_WIDTH       = 3,
  localparam int unsigned LINK_BIT_WIDTH   = $clog2(MAX_WEIGHT + 1),
  localparam int unsigned CTX_WIDTH        = (NUM_CONTEXTS > 1) ? $clog2(NUM_CONTEXTS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [STAGE_WIDTH-1:0]    global_stage,
  neighbor_link_multicontext_if.slave link,
  input  logic                      is_error_systolic_in,
  input  logic                      param_valid,
  input  logic [LINK_BIT_WIDTH-1:0] weight_in,
  input  logic [1:0]                boundary_condition_in,
  input  logic                      context_switch,
  input  logic [CTX_WIDTH-1:0]      context_next,
`ifdef NEIGHBOR_LINK_ERASURE_EN
  input  logic                      erasure_in,
`endif
  output logic [CTX_WIDTH-1:0]      active_context,
  output logic [CTX_WIDTH-1:0]      param_ptr,
  output logic                      fully_grown,
  output logic                      is_boundary,
  output logic                      is_error,
  output logic [LINK_BIT_WIDTH-1:0] weight_out,
  output logic [1:0]                boundary_condition_out
);

  localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE                = STAGE_WIDTH'(0);
  localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING = STAGE_WIDTH'(1);
  localparam logic [STAGE_WIDTH-1:0] STAGE_GROW                = STAGE_WIDTH'(2);
  localparam logic [STAGE_WIDTH-1:0] STAGE_PARAMETERS_LOADING  = STAGE_WIDTH'(3);
  localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE               = STAGE_WIDTH'(4);
  localparam logic [STAGE_WIDTH-1:0] STAGE_PEELING             = STAGE_WIDTH'(5);
  localparam logic [STAGE_WIDTH-1:0] STAGE_RESULT_VALID        = STAGE_WIDTH'(6);

  // Wide enough for growth + both increments before saturation.
  localparam int unsigned SUM_WIDTH = $clog2(MAX_WEIGHT + 3);
  localparam logic [CTX_WIDTH-1:0] LAST_CTX = CTX_WIDTH'(NUM_CONTEXTS - 1);
  localparam logic [CTX_WIDTH:0]   NUM_CTX  = (CTX_WIDTH + 1)'(NUM_CONTEXTS);

  logic [LINK_BIT_WIDTH-1:0] weight_q [NUM_CONTEXTS];
  logic [LINK_BIT_WIDTH-1:0] weight_d [NUM_CONTEXTS];
  logic [1:0]                bc_q     [NUM_CONTEXTS];
  logic [1:0]                bc_d     [NUM_CONTEXTS];
  logic [LINK_BIT_WIDTH-1:0] growth_q [NUM_CONTEXTS];
  logic [LINK_BIT_WIDTH-1:0] growth_d [NUM_CONTEXTS];
  logic                      err_q    [NUM_CONTEXTS];
  logic                      err_d    [NUM_CONTEXTS];
  logic [CTX_WIDTH-1:0]      active_context_q, active_context_d;
  logic [CTX_WIDTH-1:0]      param_ptr_q, param_ptr_d;

  logic [LINK_BIT_WIDTH-1:0]    act_weight;
  logic [1:0]                   act_bc;
  logic [LINK_BIT_WIDTH-1:0]    act_growth;
  logic [SUM_WIDTH-1:0]         growth_sum;
  logic [LINK_BIT_WIDTH-1:0]    growth_sat;
  logic [LINK_BIT_WIDTH-1:0]    growth_meas;
  logic                         err_next;
  logic                         switch_ok;
  logic                         param_wr;
  logic                         is_meas_loading;
  logic                         is_stage_known;
  logic [EXPOSED_DATA_SIZE-1:0] fwd_to_a, fwd_to_b;

  assign act_weight = weight_q[active_context_q];
  assign act_bc     = bc_q[active_context_q];
  assign act_growth = growth_q[active_context_q];

  assign switch_ok       = context_switch && ({1'b0, context_next} < NUM_CTX);
  assign param_wr        = param_valid && (global_stage == STAGE_PARAMETERS_LOADING);
  assign is_meas_loading = (global_stage == STAGE_MEASUREMENT_LOADING);

  // Stages without a dedicated action fall through to the default grow/error rules.
  assign is_stage_known = (global_stage == STAGE_IDLE) || (global_stage == STAGE_GROW) ||
                          (global_stage == STAGE_MERGE) || (global_stage == STAGE_PEELING);

  always_comb begin
    growth_sum = '0;
    if (act_bc == 2'd0) begin
      growth_sum = SUM_WIDTH'(act_growth) + SUM_WIDTH'(link.a_increase) +
                   SUM_WIDTH'(link.b_increase);
    end else if (act_bc == 2'd1) begin
      growth_sum = SUM_WIDTH'(act_growth) + SUM_WIDTH'(link.a_increase);
    end
    if (growth_sum > SUM_WIDTH'(act_weight)) begin
      growth_sat = act_weight;
    end else begin
      growth_sat = growth_sum[LINK_BIT_WIDTH-1:0];
    end
  end

`ifdef NEIGHBOR_LINK_ERASURE_EN
  // An erased link starts fully grown so the matching treats it as free.
  assign growth_meas = erasure_in ? act_weight : '0;
`else
  assign growth_meas = '0;
`endif

  always_comb begin
    err_next = 1'b0;
    if (act_bc[1]) begin
      err_next = 1'b0;
    end else if (is_meas_loading) begin
      err_next = 1'b0;
    end else if (global_stage == STAGE_RESULT_VALID) begin
      err_next = is_error_systolic_in;
    end else if (act_bc == 2'd0) begin
      err_next = link.a_is_error_in | link.b_is_error_in;
    end else begin
      err_next = link.a_is_error_in;
    end
  end

  always_comb begin
    weight_d         = weight_q;
    bc_d             = bc_q;
    growth_d         = growth_q;
    err_d            = err_q;
    active_context_d = active_context_q;
    param_ptr_d      = param_ptr_q;

    if (param_wr) begin
      weight_d[param_ptr_q] = weight_in;
      bc_d[param_ptr_q]     = boundary_condition_in;
      param_ptr_d           = (param_ptr_q == LAST_CTX) ? '0 : param_ptr_q + 1'b1;
    end

    // A context switch suppresses the stage action for that cycle on every context.
    if (switch_ok) begin
      active_context_d = context_next;
    end else begin
      growth_d[active_context_q] = is_meas_loading ? growth_meas : growth_sat;
      err_d[active_context_q]    = err_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_CONTEXTS); i++) begin
        weight_q[i] <= '0;
        bc_q[i]     <= '0;
        growth_q[i] <= '0;
        err_q[i]    <= 1'b0;
      end
      active_context_q <= '0;
      param_ptr_q      <= '0;
    end else begin
      weight_q         <= weight_d;
      bc_q             <= bc_d;
      growth_q         <= growth_d;
      err_q            <= err_d;
      active_context_q <= active_context_d;
      param_ptr_q      <= param_ptr_d;
    end
  end

  always_comb begin
    fwd_to_a = '0;
    fwd_to_b = '0;
    if (act_bc == 2'd0) begin
      fwd_to_a = link.b_input_data;
      fwd_to_b = link.a_input_data;
    end
  end

  assign link.a_output_data = fwd_to_a;
  assign link.b_output_data = fwd_to_b;

  assign active_context         = active_context_q;
  assign param_ptr              = param_ptr_q;
  assign weight_out             = act_weight;
  assign boundary_condition_out = act_bc;
  assign is_error               = err_q[active_context_q];
  assign fully_grown            = (act_growth >= act_weight) && !act_bc[1];
  assign is_boundary            = (act_bc == 2'd1) && fully_grown;

  logic unused_stage;
  assign unused_stage = is_stage_known;

endmodule
